// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache. Hits return the addressed word combinationally;
// misses stall the PC while the block is fetched with a busy-wait handshake.
module instruction_cache #(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [31:0]   pc_i,
    output logic [31:0]   instr_o,
    output logic          mem_out_ready_o,
    output logic          mem_read_o,
    output logic [27:0]   mem_address_o,
    input  logic [127:0]  mem_readdata_i,
    input  logic          mem_busywait_i
);

    localparam int unsigned Lines = 2 ** INDEX_BITS;
    localparam int unsigned TagW  = 28 - INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StFetch, StUpdate} state_e;

    state_e           state_q, state_d;
    logic [Lines-1:0] valid_q, valid_d;
    logic [TagW-1:0]  tag_q  [Lines];
    logic [127:0]     data_q [Lines];
    logic             mem_read_q, mem_read_d;
    logic [27:0]      mem_address_q, mem_address_d;
    logic [127:0]     fill_q, fill_d;

    logic [INDEX_BITS-1:0] pc_idx, fill_idx;
    logic [TagW-1:0]       pc_tag, fill_tag;
    logic [1:0]            pc_word;
    logic                  hit;
    logic [127:0]          line;
    logic [31:0]           sel_word;
    logic                  unused_pc;

    assign pc_word   = pc_i[3:2];
    assign pc_idx    = pc_i[3+INDEX_BITS:4];
    assign pc_tag    = pc_i[31:4+INDEX_BITS];
    assign fill_idx  = mem_address_q[INDEX_BITS-1:0];
    assign fill_tag  = mem_address_q[27:INDEX_BITS];
    assign unused_pc = ^pc_i[1:0];

    assign hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    always_comb begin
        line     = data_q[pc_idx];
        sel_word = '0;
        unique case (pc_word)
            2'd0: sel_word = line[31:0];
            2'd1: sel_word = line[63:32];
            2'd2: sel_word = line[95:64];
            2'd3: sel_word = line[127:96];
            default: sel_word = '0;
        endcase
    end

    // Reset gating keeps the outputs quiet even while the async reset is held.
    assign mem_out_ready_o = rst_ni && (state_q == StIdle) && hit;
    assign instr_o         = mem_out_ready_o ? sel_word : 32'h0;
    assign mem_read_o      = mem_read_q;
    assign mem_address_o   = mem_address_q;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        fill_d        = fill_q;
        unique case (state_q)
            StIdle: begin
                if (!hit) begin
                    state_d       = StFetch;
                    mem_read_d    = 1'b1;
                    mem_address_d = pc_i[31:4];
                end
            end
            StFetch: begin
                if (!mem_busywait_i) begin
                    fill_d     = mem_readdata_i;
                    mem_read_d = 1'b0;
                    state_d    = StUpdate;
                end
            end
            StUpdate: begin
                valid_d[fill_idx] = 1'b1;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            valid_q       <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            fill_q        <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            fill_q        <= fill_d;
        end
    end

    // Tag and data need no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (state_q == StUpdate) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_q;
        end
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the program counter and instruction memory. It looks up the current `pc`, returns the addressed instruction word on a hit in the same cycle, and on a miss stalls the PC via `mem_out_ready` while it fills the line from memory through a busy-wait handshake. It is the fetch stage that consumes `pc` and produces the `mem_out_ready` that gates PC advance.

## Interface
- `INDEX_BITS`, 3, log2 of the line count (default 8 lines); tag width = 28 − INDEX_BITS.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `pc`  input  32  byte fetch address, word aligned. Fields: [1:0] ignored, [3:2] word-in-block, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag.
- `instr`  output  32  instruction word for `pc`; valid only when `mem_out_ready`=1, otherwise 0.
- `mem_out_ready`  output  1  1 = `instr` valid this cycle and PC may advance; 0 = stall.
- `mem_read`  output  1  block read request to instruction memory.
- `mem_address`  output  28  block address (`pc[31:4]` latched at miss).
- `mem_readdata`  input  128  fetched block; word k at bits [32k+31:32k].
- `mem_busywait`  input  1  memory busy; data valid in a cycle where `mem_read`=1 and `mem_busywait`=0.

## Operation
- Storage per line: valid bit, tag, 128-bit data block. Only the valid bits are reset; tag/data are don't-care until valid.
- Hit = `valid[index]` and stored tag == `pc` tag, evaluated combinationally in IDLE only.
- FSM states:
  - IDLE: hit → `mem_out_ready`=1, `instr` = selected word, stay. Miss → latch `pc[31:4]` into `mem_address`, go to FETCH.
  - FETCH: `mem_read`=1, `mem_address` held. While `mem_busywait`=1 stay. When 0, capture `mem_readdata` into the fill register, go to UPDATE.
  - UPDATE: `mem_read`=0; write the fill block, tag and valid=1 into the line selected by the latched address; go to IDLE.
- `mem_out_ready`=0 in FETCH and UPDATE regardless of `pc`.
- Fill always uses the latched address; a `pc` change during FETCH/UPDATE does not redirect the fill. The next IDLE cycle re-evaluates the current `pc`.
- Replacement: the incoming block unconditionally overwrites the indexed line. There is no write path and no dirty state.
- Reset (`rst`=0, any state, asynchronous): all valid bits clear, state IDLE, `mem_read`=0, `mem_address`=0, fill register 0. `mem_out_ready`=0 and `instr`=0 are forced while `rst`=0. A fill in progress is aborted and its line is not written.

## Timing
- Hit: zero added latency; one instruction per cycle on back-to-back hits.
- Miss, memory wait of W cycles (`mem_busywait` high for W FETCH cycles):
  - C0: IDLE, miss detected.
  - C1..C(1+W): FETCH; the capture happens on the final cycle.
  - C(2+W): UPDATE.
  - C(3+W): IDLE, hit, `mem_out_ready`=1.
  - Minimum stall (W=0) is 3 cycles.
- `mem_read` rises on the C0→C1 edge and falls on the FETCH→UPDATE edge. It is never asserted in IDLE or UPDATE.
- Outputs `mem_out_ready` and `instr` are combinational from state, `pc` and the arrays. `mem_read` and `mem_address` are registered.

## Test plan
- Reset: hold `rst`=0 with `pc`=0 → `mem_out_ready`=0, `mem_read`=0, `instr`=0. Release → C0 miss, `mem_read`=1 next cycle with `mem_address`=0.
- Cold miss with W=4, block {0x33,0x22,0x11,0x00} (word3..word0) at block 0 → `mem_out_ready` low for exactly 7 cycles, then `instr`=0x00 at `pc`=0x0.
- Sequential hits: after that fill, `pc` 0x4, 0x8, 0xC → `instr` 0x11, 0x22, 0x33 on consecutive cycles, `mem_read` stays 0.
- Conflict (INDEX_BITS=3): fill 0x0, then `pc`=0x80 (same index 0, different tag) → miss and refill with `mem_address`=0x8. Returning to `pc`=0x0 → miss again.
- Reset mid-fill: assert `rst`=0 during FETCH → `mem_read` drops immediately. After release, the same `pc` misses, showing the line was not validated.
- Zero-wait memory (`mem_busywait` always 0) → stall of exactly 3 cycles per miss, and `mem_read` high for exactly one cycle.
